// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares a single 32-bit ALU between two requesters:
//   requester 0 : core datapath
//   requester 1 : address / auxiliary unit
//
// Each request is a valid/ready handshake carrying an opcode and two operands.
// Arbitration is round-robin. Each operation takes three cycles:
//   IDLE : handshake accepted, operands registered
//   EXEC : registered operands drive the ALU, result/zero registered
//   RESP : response held until the owner consumes it
// The priority pointer flips only when a response completes. It never flips
// on acceptance, so a requester that lost a tie always wins the next round.
//
// Each requester also has a saturating grant counter for performance
// visibility.
//
// Ports
//   clk                    rising-edge clock
//   reset                  synchronous, active-high reset
//   R0_/R1_Valid_i         request valid
//   R0_/R1_Ready_o         request accepted (combinational, one-hot or zero)
//   R0_/R1_Op_i            ALU opcode
//   R0_/R1_A_i, _B_i       operands
//   R0_/R1_Rsp_Valid_o     response valid for that requester
//   R0_/R1_Rsp_Ready_i     requester consumes its response
//   Result_o, Zero_o       registered ALU result and zero flag
//   Busy_o                 high whenever the arbiter is not idle
//   R0_/R1_Grant_Cnt_o     saturating accepted-request counters
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             R0_Valid_i,
    output logic             R0_Ready_o,
    input  logic [3:0]       R0_Op_i,
    input  logic [31:0]      R0_A_i,
    input  logic [31:0]      R0_B_i,
    output logic             R0_Rsp_Valid_o,
    input  logic             R0_Rsp_Ready_i,

    input  logic             R1_Valid_i,
    output logic             R1_Ready_o,
    input  logic [3:0]       R1_Op_i,
    input  logic [31:0]      R1_A_i,
    input  logic [31:0]      R1_B_i,
    output logic             R1_Rsp_Valid_o,
    input  logic             R1_Rsp_Ready_i,

    output logic [31:0]      Result_o,
    output logic             Zero_o,
    output logic             Busy_o,
    output logic [CNT_W-1:0] R0_Grant_Cnt_o,
    output logic [CNT_W-1:0] R1_Grant_Cnt_o
);

    localparam int N_REQ = 2;

    // ALU opcodes
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_LUI = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Requester-indexed views of the flat port list
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] rsp_ready;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] ready;
    logic [N_REQ-1:0] rsp_valid;
    logic [3:0]       req_op [N_REQ];
    logic [31:0]      req_a  [N_REQ];
    logic [31:0]      req_b  [N_REQ];

    assign req_valid = {R1_Valid_i, R0_Valid_i};
    assign rsp_ready = {R1_Rsp_Ready_i, R0_Rsp_Ready_i};

    assign req_op[0] = R0_Op_i;
    assign req_op[1] = R1_Op_i;
    assign req_a[0]  = R0_A_i;
    assign req_a[1]  = R1_A_i;
    assign req_b[0]  = R0_B_i;
    assign req_b[1]  = R1_B_i;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_reg, state_next;
    logic        prio_reg, prio_next;
    logic        owner_reg, owner_next;
    logic [3:0]  op_reg;
    logic [31:0] a_reg, b_reg;
    logic [31:0] result_reg;
    logic        zero_reg;
    logic [CNT_W-1:0] cnt_reg [N_REQ];

    logic        accept;
    logic        accept_idx;
    logic        load_result;

    // ALU outputs
    logic [31:0] alu_result;
    logic        alu_zero;

    // -------------------------------------------------------------------------
    // Arbitration: a lone requester always wins. On a tie, prio decides.
    // The grant is only acted on in IDLE, through ready.
    // -------------------------------------------------------------------------
    always_comb begin
        grant = '0;
        if (req_valid == 2'b11) begin
            grant[prio_reg] = 1'b1;
        end else begin
            grant = req_valid;
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            localparam logic REQ_ID = 1'(gi);

            // Masking with reset keeps ready low during the reset cycle,
            // even if a requester is already presenting valid.
            assign ready[gi]     = (state_reg == IDLE) & grant[gi] & ~reset;
            assign rsp_valid[gi] = (state_reg == RESP) & (owner_reg == REQ_ID);

            // Saturating grant counter. It sticks at all-ones.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (ready[gi] && req_valid[gi] && (cnt_reg[gi] != '1)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    // ready is one-hot or zero, so ready[1] alone identifies the winner
    assign accept     = |(ready & req_valid);
    assign accept_idx = ready[1];

    // -------------------------------------------------------------------------
    // Shared ALU, driven only from the operand registers
    // -------------------------------------------------------------------------
    always_comb begin
        alu_result = '0;
        case (op_reg)
            OP_ADD:  alu_result = a_reg + b_reg;
            OP_OR:   alu_result = a_reg | b_reg;
            OP_LUI:  alu_result = {b_reg[19:0], 12'b0};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        prio_next   = prio_reg;
        owner_next  = owner_reg;
        load_result = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    owner_next = accept_idx;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                load_result = 1'b1;
                state_next  = RESP;
            end
            RESP: begin
                // Only the owner's consume counts. The other requester's
                // Rsp_Ready is ignored.
                if (rsp_ready[owner_reg]) begin
                    prio_next  = ~owner_reg;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            owner_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
            owner_reg <= owner_next;
        end
    end

    // Operands are captured on the handshake edge. Holding them afterwards
    // means the requester may change its inputs as soon as it is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
        end else if (accept) begin
            op_reg <= req_op[accept_idx];
            a_reg  <= req_a[accept_idx];
            b_reg  <= req_b[accept_idx];
        end
    end

    // The result is written only in EXEC, so it stays stable through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg <= '0;
            zero_reg   <= 1'b0;
        end else if (load_result) begin
            result_reg <= alu_result;
            zero_reg   <= alu_zero;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign R0_Ready_o     = ready[0];
    assign R1_Ready_o     = ready[1];
    assign R0_Rsp_Valid_o = rsp_valid[0];
    assign R1_Rsp_Valid_o = rsp_valid[1];
    assign Result_o       = result_reg;
    assign Zero_o         = zero_reg;
    assign Busy_o         = (state_reg != IDLE);
    assign R0_Grant_Cnt_o = cnt_reg[0];
    assign R1_Grant_Cnt_o = cnt_reg[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. Every expected value is hand-computed.
//
// Two instances are used:
//   u_dut  default counter width, used for the functional scenarios
//   u_sat  CNT_W=2, used to show counter saturation
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 1-2 time units after that edge, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    // ---------------------------------------------------------------------
    // Main DUT signals
    // ---------------------------------------------------------------------
    logic        r0_valid, r1_valid, r0_rsp_ready, r1_rsp_ready;
    logic [3:0]  r0_op, r1_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic        R0_Ready_o, R1_Ready_o, R0_Rsp_Valid_o, R1_Rsp_Valid_o;
    logic [31:0] Result_o;
    logic        Zero_o, Busy_o;
    logic [15:0] R0_Grant_Cnt_o, R1_Grant_Cnt_o;

    // ---------------------------------------------------------------------
    // Saturation DUT signals
    // ---------------------------------------------------------------------
    logic        s_r0_valid, s_r1_valid, s_r0_rsp_ready, s_r1_rsp_ready;
    logic [3:0]  s_r0_op, s_r1_op;
    logic [31:0] s_r0_a, s_r0_b, s_r1_a, s_r1_b;
    logic        s_R0_Ready_o, s_R1_Ready_o, s_R0_Rsp_Valid_o, s_R1_Rsp_Valid_o;
    logic [31:0] s_Result_o;
    logic        s_Zero_o, s_Busy_o;
    logic [1:0]  s_R0_Grant_Cnt_o, s_R1_Grant_Cnt_o;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(16)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .R0_Valid_i     (r0_valid),
        .R0_Ready_o     (R0_Ready_o),
        .R0_Op_i        (r0_op),
        .R0_A_i         (r0_a),
        .R0_B_i         (r0_b),
        .R0_Rsp_Valid_o (R0_Rsp_Valid_o),
        .R0_Rsp_Ready_i (r0_rsp_ready),
        .R1_Valid_i     (r1_valid),
        .R1_Ready_o     (R1_Ready_o),
        .R1_Op_i        (r1_op),
        .R1_A_i         (r1_a),
        .R1_B_i         (r1_b),
        .R1_Rsp_Valid_o (R1_Rsp_Valid_o),
        .R1_Rsp_Ready_i (r1_rsp_ready),
        .Result_o       (Result_o),
        .Zero_o         (Zero_o),
        .Busy_o         (Busy_o),
        .R0_Grant_Cnt_o (R0_Grant_Cnt_o),
        .R1_Grant_Cnt_o (R1_Grant_Cnt_o)
    );

    alu_arbiter #(.CNT_W(2)) u_sat (
        .clk            (clk),
        .reset          (reset),
        .R0_Valid_i     (s_r0_valid),
        .R0_Ready_o     (s_R0_Ready_o),
        .R0_Op_i        (s_r0_op),
        .R0_A_i         (s_r0_a),
        .R0_B_i         (s_r0_b),
        .R0_Rsp_Valid_o (s_R0_Rsp_Valid_o),
        .R0_Rsp_Ready_i (s_r0_rsp_ready),
        .R1_Valid_i     (s_r1_valid),
        .R1_Ready_o     (s_R1_Ready_o),
        .R1_Op_i        (s_r1_op),
        .R1_A_i         (s_r1_a),
        .R1_B_i         (s_r1_b),
        .R1_Rsp_Valid_o (s_R1_Rsp_Valid_o),
        .R1_Rsp_Ready_i (s_r1_rsp_ready),
        .Result_o       (s_Result_o),
        .Zero_o         (s_Zero_o),
        .Busy_o         (s_Busy_o),
        .R0_Grant_Cnt_o (s_R0_Grant_Cnt_o),
        .R1_Grant_Cnt_o (s_R1_Grant_Cnt_o)
    );

    // ---------------------------------------------------------------------
    // Stimulus helpers (drive only, no comparisons)
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        r0_valid = 0; r1_valid = 0; r0_rsp_ready = 0; r1_rsp_ready = 0;
        r0_op = 0; r1_op = 0; r0_a = 0; r0_b = 0; r1_a = 0; r1_b = 0;
        s_r0_valid = 0; s_r1_valid = 0; s_r0_rsp_ready = 0; s_r1_rsp_ready = 0;
        s_r0_op = 0; s_r1_op = 0; s_r0_a = 0; s_r0_b = 0; s_r1_a = 0; s_r1_b = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Issue one request from idx and stop once the DUT is in RESP.
    // The response is held: both Rsp_Ready inputs are low on return.
    task automatic do_op(input bit idx, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        bit got;
        got = 1'b0;
        r0_rsp_ready = 0;
        r1_rsp_ready = 0;
        if (idx == 1'b0) begin
            r0_valid = 1; r0_op = op; r0_a = a; r0_b = b;
        end else begin
            r1_valid = 1; r1_op = op; r1_a = a; r1_b = b;
        end
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            got = (idx == 1'b0) ? R0_Ready_o : R1_Ready_o;
            if (!got) tick();
        end
        checks++;
        if (!got) $display("FAIL do_op_ready_timeout: req %0d got ready=0 want 1 within 8 cycles", idx);
        else passes++;
        tick();                 // handshake edge
        r0_valid = 0;
        r1_valid = 0;
        tick();                 // EXEC -> RESP
    endtask

    task automatic finish_rsp(input bit idx);
        if (idx == 1'b0) r0_rsp_ready = 1; else r1_rsp_ready = 1;
        tick();
        r0_rsp_ready = 0;
        r1_rsp_ready = 0;
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        r0_valid = 1; r1_valid = 1; r0_rsp_ready = 0; r1_rsp_ready = 0;
        r0_op = 0; r1_op = 0; r0_a = 0; r0_b = 0; r1_a = 0; r1_b = 0;
        s_r0_valid = 0; s_r1_valid = 0; s_r0_rsp_ready = 0; s_r1_rsp_ready = 0;
        s_r0_op = 0; s_r1_op = 0; s_r0_a = 0; s_r0_b = 0; s_r1_a = 0; s_r1_b = 0;
        tick();
        #1;
        checks++; if (R0_Ready_o !== 1'b0) $display("FAIL reset_r0_ready: got %b want 0", R0_Ready_o); else passes++;
        checks++; if (R1_Ready_o !== 1'b0) $display("FAIL reset_r1_ready: got %b want 0", R1_Ready_o); else passes++;
        checks++; if (Busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy_o); else passes++;
        checks++; if (Result_o !== 32'd0) $display("FAIL reset_result: got %h want 0", Result_o); else passes++;
        checks++; if (Zero_o !== 1'b0) $display("FAIL reset_zero: got %b want 0", Zero_o); else passes++;
        checks++; if ({R0_Rsp_Valid_o, R1_Rsp_Valid_o} !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", {R0_Rsp_Valid_o, R1_Rsp_Valid_o}); else passes++;
        checks++; if (R0_Grant_Cnt_o !== 16'd0) $display("FAIL reset_cnt0: got %0d want 0", R0_Grant_Cnt_o); else passes++;
        checks++; if (R1_Grant_Cnt_o !== 16'd0) $display("FAIL reset_cnt1: got %0d want 0", R1_Grant_Cnt_o); else passes++;
        r0_valid = 0;
        r1_valid = 0;
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single_add();
        apply_reset();
        r0_valid = 1; r0_op = 4'b0000; r0_a = 32'd5; r0_b = 32'd7; r0_rsp_ready = 1;
        #1;
        checks++; if (R0_Ready_o !== 1'b1) $display("FAIL add_r0_ready: got %b want 1", R0_Ready_o); else passes++;
        checks++; if (R1_Ready_o !== 1'b0) $display("FAIL add_r1_ready: got %b want 0", R1_Ready_o); else passes++;
        tick();                         // E0: handshake
        r0_valid = 0;
        checks++; if (Busy_o !== 1'b1) $display("FAIL add_busy_exec: got %b want 1", Busy_o); else passes++;
        checks++; if (R0_Rsp_Valid_o !== 1'b0) $display("FAIL add_rsp_early: got %b want 0", R0_Rsp_Valid_o); else passes++;
        checks++; if (R0_Grant_Cnt_o !== 16'd1) $display("FAIL add_cnt0: got %0d want 1", R0_Grant_Cnt_o); else passes++;
        tick();                         // E0+1: result registered
        checks++; if (R0_Rsp_Valid_o !== 1'b1) $display("FAIL add_rsp_valid: got %b want 1", R0_Rsp_Valid_o); else passes++;
        checks++; if (R1_Rsp_Valid_o !== 1'b0) $display("FAIL add_r1_rsp_valid: got %b want 0", R1_Rsp_Valid_o); else passes++;
        checks++; if (Result_o !== 32'd12) $display("FAIL add_result: got %h want 0000000c", Result_o); else passes++;
        checks++; if (Zero_o !== 1'b0) $display("FAIL add_zero: got %b want 0", Zero_o); else passes++;
        tick();                         // E0+2: response consumed
        checks++; if (R0_Rsp_Valid_o !== 1'b0) $display("FAIL add_rsp_done: got %b want 0", R0_Rsp_Valid_o); else passes++;
        checks++; if (Busy_o !== 1'b0) $display("FAIL add_busy_idle: got %b want 0", Busy_o); else passes++;
        r0_rsp_ready = 0;
        $display("test_single_add done: result=%h", Result_o);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        r0_valid = 1; r0_op = 4'b0000; r0_a = 32'd1;    r0_b = 32'd1;
        r1_valid = 1; r1_op = 4'b0010; r1_a = 32'hF0;   r1_b = 32'h0F;
        r0_rsp_ready = 1; r1_rsp_ready = 1;
        #1;
        checks++; if (R0_Ready_o !== 1'b1) $display("FAIL sim1_r0_ready: got %b want 1", R0_Ready_o); else passes++;
        checks++; if (R1_Ready_o !== 1'b0) $display("FAIL sim1_r1_ready: got %b want 0", R1_Ready_o); else passes++;
        tick();                         // R0 accepted, R1 keeps waiting
        r0_valid = 0;
        #1;
        checks++; if (R1_Ready_o !== 1'b0) $display("FAIL sim1_r1_ready_exec: got %b want 0", R1_Ready_o); else passes++;
        tick();
        checks++; if (R0_Rsp_Valid_o !== 1'b1) $display("FAIL sim1_r0_rsp: got %b want 1", R0_Rsp_Valid_o); else passes++;
        checks++; if (Result_o !== 32'd2) $display("FAIL sim1_result: got %h want 00000002", Result_o); else passes++;
        tick();                         // R0 response done, prio -> 1
        checks++; if (R1_Ready_o !== 1'b1) $display("FAIL sim2_r1_ready: got %b want 1", R1_Ready_o); else passes++;
        tick();                         // R1 accepted
        r1_valid = 0;
        tick();
        checks++; if (R1_Rsp_Valid_o !== 1'b1) $display("FAIL sim2_r1_rsp: got %b want 1", R1_Rsp_Valid_o); else passes++;
        checks++; if (R0_Rsp_Valid_o !== 1'b0) $display("FAIL sim2_r0_rsp: got %b want 0", R0_Rsp_Valid_o); else passes++;
        checks++; if (Result_o !== 32'h000000FF) $display("FAIL sim2_result: got %h want 000000ff", Result_o); else passes++;
        tick();                         // R1 response done, prio -> 0
        r0_valid = 1; r1_valid = 1;
        #1;
        checks++; if (R0_Ready_o !== 1'b1) $display("FAIL sim3_r0_ready: got %b want 1", R0_Ready_o); else passes++;
        checks++; if (R1_Ready_o !== 1'b0) $display("FAIL sim3_r1_ready: got %b want 0", R1_Ready_o); else passes++;
        checks++; if (R1_Grant_Cnt_o !== 16'd1) $display("FAIL sim3_cnt1: got %0d want 1", R1_Grant_Cnt_o); else passes++;
        tick();
        r0_valid = 0; r1_valid = 0;
        checks++; if (R0_Grant_Cnt_o !== 16'd2) $display("FAIL sim3_cnt0: got %0d want 2", R0_Grant_Cnt_o); else passes++;
        tick();
        tick();
        r0_rsp_ready = 0; r1_rsp_ready = 0;
        $display("test_simultaneous done: cnt0=%0d cnt1=%0d", R0_Grant_Cnt_o, R1_Grant_Cnt_o);
    endtask

    task automatic test_backpressure();
        apply_reset();
        r1_valid = 1; r1_op = 4'b0100; r1_a = 32'h0000DEAD; r1_b = 32'h00012345;
        r1_rsp_ready = 0; r0_rsp_ready = 1;
        #1;
        checks++; if (R1_Ready_o !== 1'b1) $display("FAIL bp_r1_ready: got %b want 1", R1_Ready_o); else passes++;
        tick();                         // R1 accepted
        r1_valid = 0;
        r0_valid = 1; r0_op = 4'b0000; r0_a = 32'd0; r0_b = 32'd0;
        tick();                         // result registered, RESP
        for (int i = 0; i < 5; i++) begin
            checks++; if (Result_o !== 32'h12345000) $display("FAIL bp_result_%0d: got %h want 12345000", i, Result_o); else passes++;
            checks++; if (R1_Rsp_Valid_o !== 1'b1) $display("FAIL bp_rsp_valid_%0d: got %b want 1", i, R1_Rsp_Valid_o); else passes++;
            checks++; if (R0_Ready_o !== 1'b0) $display("FAIL bp_r0_ready_%0d: got %b want 0", i, R0_Ready_o); else passes++;
            tick();
        end
        r1_rsp_ready = 1;
        #1;
        checks++; if (R1_Rsp_Valid_o !== 1'b1) $display("FAIL bp_rsp_held: got %b want 1", R1_Rsp_Valid_o); else passes++;
        tick();                         // first edge with Rsp_Ready=1
        r1_rsp_ready = 0;
        checks++; if (R1_Rsp_Valid_o !== 1'b0) $display("FAIL bp_rsp_done: got %b want 0", R1_Rsp_Valid_o); else passes++;
        checks++; if (R0_Ready_o !== 1'b1) $display("FAIL bp_r0_ready_after: got %b want 1", R0_Ready_o); else passes++;
        tick();                         // R0 accepted
        r0_valid = 0;
        tick();
        tick();
        r0_rsp_ready = 0;
        $display("test_backpressure done");
    endtask

    task automatic test_zero_flag();
        apply_reset();
        do_op(1'b0, 4'b1111, 32'd3, 32'd4);
        checks++; if (Result_o !== 32'd0) $display("FAIL z_badop_result: got %h want 00000000", Result_o); else passes++;
        checks++; if (Zero_o !== 1'b1) $display("FAIL z_badop_zero: got %b want 1", Zero_o); else passes++;
        finish_rsp(1'b0);
        do_op(1'b0, 4'b0000, 32'hFFFFFFFF, 32'd1);
        checks++; if (Result_o !== 32'd0) $display("FAIL z_wrap_result: got %h want 00000000", Result_o); else passes++;
        checks++; if (Zero_o !== 1'b1) $display("FAIL z_wrap_zero: got %b want 1", Zero_o); else passes++;
        finish_rsp(1'b0);
        do_op(1'b1, 4'b0000, 32'h12345678, 32'h11111111);
        checks++; if (Result_o !== 32'h23456789) $display("FAIL z_add_result: got %h want 23456789", Result_o); else passes++;
        checks++; if (Zero_o !== 1'b0) $display("FAIL z_add_zero: got %b want 0", Zero_o); else passes++;
        finish_rsp(1'b1);
        do_op(1'b0, 4'b0010, 32'hA0A00000, 32'h0000050F);
        checks++; if (Result_o !== 32'hA0A0050F) $display("FAIL z_or_result: got %h want a0a0050f", Result_o); else passes++;
        finish_rsp(1'b0);
        do_op(1'b1, 4'b0001, 32'd9, 32'd2);
        checks++; if (Result_o !== 32'd0) $display("FAIL z_op1_result: got %h want 00000000", Result_o); else passes++;
        checks++; if (Zero_o !== 1'b1) $display("FAIL z_op1_zero: got %b want 1", Zero_o); else passes++;
        finish_rsp(1'b1);
        $display("test_zero_flag done");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_op(1'b0, 4'b0000, 32'd1, 32'd2);     // leaves prio=1 after completion
        finish_rsp(1'b0);
        r1_valid = 1; r1_op = 4'b0000; r1_a = 32'd4; r1_b = 32'd4;
        #1;
        checks++; if (R1_Ready_o !== 1'b1) $display("FAIL rm_r1_ready: got %b want 1", R1_Ready_o); else passes++;
        tick();                         // accepted, now in EXEC
        r1_valid = 0;
        checks++; if (Busy_o !== 1'b1) $display("FAIL rm_busy_exec: got %b want 1", Busy_o); else passes++;
        reset = 1'b1;
        tick();                         // reset edge during EXEC
        reset = 1'b0;
        r0_rsp_ready = 1; r1_rsp_ready = 1;
        checks++; if (Busy_o !== 1'b0) $display("FAIL rm_busy: got %b want 0", Busy_o); else passes++;
        checks++; if (R0_Grant_Cnt_o !== 16'd0) $display("FAIL rm_cnt0: got %0d want 0", R0_Grant_Cnt_o); else passes++;
        checks++; if (R1_Grant_Cnt_o !== 16'd0) $display("FAIL rm_cnt1: got %0d want 0", R1_Grant_Cnt_o); else passes++;
        checks++; if (Result_o !== 32'd0) $display("FAIL rm_result: got %h want 00000000", Result_o); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({R0_Rsp_Valid_o, R1_Rsp_Valid_o} !== 2'b00) $display("FAIL rm_no_rsp_%0d: got %b want 00", i, {R0_Rsp_Valid_o, R1_Rsp_Valid_o}); else passes++;
            tick();
        end
        r0_rsp_ready = 0; r1_rsp_ready = 0;
        r0_valid = 1; r1_valid = 1;
        #1;
        checks++; if (R0_Ready_o !== 1'b1) $display("FAIL rm_r0_wins: got %b want 1", R0_Ready_o); else passes++;
        checks++; if (R1_Ready_o !== 1'b0) $display("FAIL rm_r1_loses: got %b want 0", R1_Ready_o); else passes++;
        r0_valid = 0; r1_valid = 0;
        // Reset in RESP: the held response disappears.
        do_op(1'b1, 4'b0010, 32'h1, 32'h2);
        checks++; if (R1_Rsp_Valid_o !== 1'b1) $display("FAIL rm_resp_before: got %b want 1", R1_Rsp_Valid_o); else passes++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (R1_Rsp_Valid_o !== 1'b0) $display("FAIL rm_resp_after: got %b want 0", R1_Rsp_Valid_o); else passes++;
        checks++; if (Result_o !== 32'd0) $display("FAIL rm_resp_result: got %h want 00000000", Result_o); else passes++;
        $display("test_reset_mid done");
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        bit got;
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        apply_reset();
        s_r1_valid = 1; s_r1_op = 4'b0000; s_r1_a = 32'd1; s_r1_b = 32'd1;
        s_r1_rsp_ready = 1;
        for (int n = 0; n < 5; n++) begin
            got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                #1;
                got = s_R1_Ready_o;
                if (!got) tick();
            end
            checks++; if (!got) $display("FAIL sat_ready_timeout_%0d: got ready=0 want 1 within 8 cycles", n); else passes++;
            tick();                     // handshake
            checks++; if (s_R1_Grant_Cnt_o !== exp_cnt[n]) $display("FAIL sat_cnt_%0d: got %0d want %0d", n, s_R1_Grant_Cnt_o, exp_cnt[n]); else passes++;
            $display("test_saturation grant %0d: cnt=%0d", n, s_R1_Grant_Cnt_o);
        end
        s_r1_valid = 0;
        tick();
        tick();
        s_r1_rsp_ready = 0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_simultaneous();
        test_backpressure();
        test_zero_flag();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Time limit so a stuck handshake can never hang the run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion before 200000");
        $fatal(1, "time limit reached");
    end

endmodule
